// File: rtl/fp_accum_ctrl.sv
// fp_accum_ctrl: sequences an FP32 operand stream through a shared adder.
// Ports: start/len launch a run, in_* stream, add_* adder, busy/done/result.
module fp_accum_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  len,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_sum,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ADD,
    DONE
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  cnt, cnt_nx;
  logic [31:0] acc, acc_nx;
  logic [31:0] opr, opr_nx;
  logic        first, first_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 8'd0;
      acc   <= 32'd0;
      opr   <= 32'd0;
      first <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      acc   <= acc_nx;
      opr   <= opr_nx;
      first <= first_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    acc_nx   = acc;
    opr_nx   = opr;
    first_nx = first;
    unique case (state)
      IDLE: begin
        if (start) begin
          cnt_nx   = len;
          acc_nx   = 32'd0;
          first_nx = 1'b1;
          state_nx = (len == 8'd0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (in_valid) begin
          cnt_nx = cnt - 8'd1;
          if (first) begin
            // adder has no zero handling, so seed acc directly
            acc_nx   = in_data;
            first_nx = 1'b0;
            state_nx = (cnt == 8'd1) ? DONE : FETCH;
          end else begin
            opr_nx   = in_data;
            state_nx = ADD;
          end
        end
      end
      ADD: begin
        acc_nx   = add_sum;
        state_nx = (cnt == 8'd0) ? DONE : FETCH;
      end
      DONE: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign in_ready = (state == FETCH);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign result   = acc;
  assign add_a    = acc;
  assign add_b    = opr;

endmodule

// File: tb/tb_fp_accum_ctrl.sv
// tb_fp_accum_ctrl: directed runs against a cycle-level behavioural model.
// Includes a simple FP32 adder for normal values built on real arithmetic.
module tb_fp_accum_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = 8'd0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_ready;
  logic [31:0] add_a, add_b, add_sum;
  logic        busy, done;
  logic [31:0] result;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int dcnt = 0;
  bit rdy_seen = 0;
  bit chk_on = 0;

  fp_accum_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic real f2d(input logic [31:0] b);
    logic [63:0] d;
    if (b[30:0] == 31'd0) return 0.0;
    d = {b[31], 11'(b[30:23]) - 11'd127 + 11'd1023, b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] d2f(input real r);
    logic [63:0] b;
    logic [10:0] e;
    b = $realtobits(r);
    if (b[62:0] == 63'd0) return 32'd0;
    e = b[62:52] - 11'd1023 + 11'd127;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  assign add_sum = d2f(f2d(add_a) + f2d(add_b));

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  // behavioural model: operands taken, remaining, running real sum
  logic        e_busy, e_ready, e_done, m_add;
  logic [31:0] e_res;
  int          m_rem, m_got;
  real         m_sum;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_busy <= 0; e_ready <= 0; e_done <= 0; m_add <= 0;
      e_res <= 32'd0; m_rem <= 0; m_got <= 0; m_sum <= 0.0;
    end else if (e_done) begin
      e_done <= 0;
      e_busy <= 0;
    end else if (!e_busy) begin
      if (start) begin
        m_rem <= int'(len);
        m_got <= 0;
        m_sum <= 0.0;
        e_busy <= 1;
        if (len == 8'd0) begin
          e_done <= 1;
          e_res <= 32'd0;
        end else begin
          e_ready <= 1;
        end
      end
    end else if (e_ready) begin
      if (in_valid) begin
        m_got <= m_got + 1;
        m_rem <= m_rem - 1;
        m_sum <= m_sum + f2d(in_data);
        if (m_got == 0 && m_rem == 1) begin
          e_ready <= 0;
          e_done <= 1;
          e_res <= d2f(m_sum + f2d(in_data));
        end else if (m_got > 0) begin
          e_ready <= 0;
          m_add <= 1;
        end
      end
    end else if (m_add) begin
      m_add <= 0;
      if (m_rem == 0) begin
        e_done <= 1;
        e_res <= d2f(m_sum);
      end else begin
        e_ready <= 1;
      end
    end
  end

  always @(negedge clk) begin
    if (done === 1'b1) dcnt++;
    if (in_ready === 1'b1) rdy_seen = 1;
    if (chk_on) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, e_ready});
      chk("busy", {31'd0, busy}, {31'd0, e_busy});
      chk("done", {31'd0, done}, {31'd0, e_done});
      if (e_done || !e_busy) chk("result", result, e_res);
    end
  end

  int t0, td;

  task automatic start_run(input int l, input bit hold);
    start = 1;
    len = 8'(l);
    t0 = cyc;
    @(negedge clk);
    if (!hold) start = 0;
  endtask

  task automatic feed(input logic [31:0] d);
    int k = 0;
    in_valid = 1;
    in_data = d;
    while (in_ready !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("feed_timeout", {31'd0, k >= 40}, 32'd0);
    @(negedge clk);
  endtask

  task automatic wait_done(input bit hold);
    int k = 0;
    while (done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("done_timeout", {31'd0, k >= 40}, 32'd0);
    td = cyc;
    if (hold) begin
      @(negedge clk);
      start = 0;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    rst_n = 1;
    chk_on = 1;
    @(negedge clk);

    // three operands, valid held high
    dcnt = 0;
    start_run(3, 0);
    feed(32'h3F800000);
    feed(32'h40000000);
    feed(32'h40400000);
    in_valid = 0;
    wait_done(0);
    chk("len3_lat", td - t0, 32'd6);
    chk("len3_res", result, 32'h40C00000);
    @(negedge clk);
    chk("len3_idle", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);

    // empty run
    rdy_seen = 0;
    start_run(0, 0);
    wait_done(0);
    chk("len0_lat", td - t0, 32'd1);
    chk("len0_res", result, 32'd0);
    repeat (2) @(negedge clk);
    chk("len0_noready", {31'd0, rdy_seen}, 32'd0);

    // single operand bypasses the adder
    start_run(1, 0);
    feed(32'h3FC00000);
    in_valid = 0;
    wait_done(0);
    chk("len1_lat", td - t0, 32'd2);
    chk("len1_res", result, 32'h3FC00000);
    repeat (2) @(negedge clk);

    // valid gaps between operands
    dcnt = 0;
    start_run(2, 0);
    feed(32'h40000000);
    in_valid = 0;
    repeat (3) begin
      chk("gap_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
    end
    feed(32'hC0000000);
    in_valid = 0;
    wait_done(0);
    chk("gap_res", result, 32'd0);
    repeat (3) @(negedge clk);
    chk("gap_done_once", dcnt, 32'd1);

    // reset in the middle of a run
    dcnt = 0;
    start_run(4, 0);
    feed(32'h3F800000);
    feed(32'h3F800000);
    in_valid = 0;
    rst_n = 0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk("mid_rst_nodone", dcnt, 32'd0);
    start_run(2, 0);
    feed(32'h3F000000);
    feed(32'h3F000000);
    in_valid = 0;
    wait_done(0);
    chk("post_rst_res", result, 32'h3F800000);
    repeat (2) @(negedge clk);

    // start held through FETCH, ADD and DONE
    dcnt = 0;
    start_run(2, 1);
    feed(32'h3F800000);
    feed(32'h40000000);
    in_valid = 0;
    wait_done(1);
    chk("hold_lat", td - t0, 32'd4);
    chk("hold_res", result, 32'h40400000);
    chk("hold_idle", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("hold_done_once", dcnt, 32'd1);
    chk("hold_still_idle", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
